// File: rtl/rf_write_scheduler_pkg.sv
// Shared constants for the RegFile write scheduler: the hard-wired zero register and
// the round-robin grant encodings.
package rf_write_scheduler_pkg;
  localparam int REG_X0 = 0;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;
endpackage

// File: rtl/rf_write_scheduler_if.sv
// Writeback request, scoreboard mark/check and RegFile write-port bundle.
// WB_BYPASS_EN adds the in-flight bypass outputs.
interface rf_write_scheduler_if #(
  parameter int WIDTH        = 32,
  parameter int ADRESS_WIDTH = 5
);
  logic                    alu_valid, alu_ready;
  logic [ADRESS_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]        alu_data;
  logic                    lsu_valid, lsu_ready;
  logic [ADRESS_WIDTH-1:0] lsu_rd;
  logic [WIDTH-1:0]        lsu_data;
  logic                    mark_valid;
  logic [ADRESS_WIDTH-1:0] mark_rd;
  logic [ADRESS_WIDTH-1:0] chk_addr0, chk_addr1;
  logic                    chk_busy0, chk_busy1;
  logic                    rf_we;
  logic [ADRESS_WIDTH-1:0] rf_waddr;
  logic [WIDTH-1:0]        rf_wdata;
  logic                    sb_err;
`ifdef WB_BYPASS_EN
  logic                    byp_hit0, byp_hit1;
  logic [WIDTH-1:0]        byp_data0, byp_data1;
`endif

  modport slave (
`ifdef WB_BYPASS_EN
    output byp_hit0, byp_hit1, byp_data0, byp_data1,
`endif
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, chk_addr0, chk_addr1,
    output alu_ready, lsu_ready, chk_busy0, chk_busy1,
           rf_we, rf_waddr, rf_wdata, sb_err
  );

  modport master (
`ifdef WB_BYPASS_EN
    input  byp_hit0, byp_hit1, byp_data0, byp_data1,
`endif
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, chk_addr0, chk_addr1,
    input  alu_ready, lsu_ready, chk_busy0, chk_busy1,
           rf_we, rf_waddr, rf_wdata, sb_err
  );
endinterface

// File: rtl/rf_write_scheduler_scoreboard.sv
// Pending-write scoreboard: set/clear with set priority, sticky protocol error, and the
// two hazard lookups. WB_BYPASS_EN drops the in-flight term from busy and exports it as a hit.
module rf_scoreboard
  import rf_write_scheduler_pkg::*;
#(
  parameter int ADRESS_WIDTH = 5,
  parameter int DEPTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mark_valid_i,
  input  logic [ADRESS_WIDTH-1:0]      mark_rd_i,
  input  logic                         clr_valid_i,
  input  logic [ADRESS_WIDTH-1:0]      clr_rd_i,
  input  logic                         rf_we_i,
  input  logic [ADRESS_WIDTH-1:0]      rf_waddr_i,
  input  logic [1:0][ADRESS_WIDTH-1:0] chk_addr_i,
  output logic [1:0]                   busy_o,
`ifdef WB_BYPASS_EN
  output logic [1:0]                   hit_o,
`endif
  output logic                         sb_err_o
);
  logic [DEPTH-1:0] pending_q, pending_d;
  logic             err_q, err_d;
  logic             mark_eff;

  always_comb begin
    mark_eff  = mark_valid_i && (mark_rd_i != ADRESS_WIDTH'(REG_X0));
    pending_d = pending_q;
    if (clr_valid_i) pending_d[clr_rd_i] = 1'b0;
    if (mark_eff)    pending_d[mark_rd_i] = 1'b1;  // set wins over same-cycle clear
    err_d = err_q
          | (mark_eff && pending_q[mark_rd_i] && !(clr_valid_i && clr_rd_i == mark_rd_i))
          | (clr_valid_i && !pending_q[clr_rd_i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_chk
    logic nz, infl;
    assign nz   = chk_addr_i[k] != ADRESS_WIDTH'(REG_X0);
    assign infl = rf_we_i && (rf_waddr_i == chk_addr_i[k]);
`ifdef WB_BYPASS_EN
    assign busy_o[k] = nz && pending_q[chk_addr_i[k]];
    assign hit_o[k]  = nz && infl;
`else
    assign busy_o[k] = nz && (pending_q[chk_addr_i[k]] || infl);
`endif
  end

  assign sb_err_o = err_q;
endmodule

// File: rtl/rf_write_scheduler.sv
// RegFile write-port owner: round-robin ALU/LSU writeback arbiter, registered write port
// and pending-write scoreboard. Optional WB_BYPASS_EN exports in-flight bypass data.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADRESS_WIDTH = 5,
  parameter int DEPTH        = 32
) (
  input logic            clk,
  input logic            rst,
  rf_write_scheduler_if.slave bus
);
  grant_t                  last_q, last_d;
  logic                    alu_gnt, lsu_gnt;
  logic [ADRESS_WIDTH-1:0] win_rd;
  logic [WIDTH-1:0]        win_data;
  logic                    we_q, we_d;
  logic [ADRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic [1:0]              busy;

  always_comb begin
    alu_gnt  = bus.alu_valid && (!bus.lsu_valid || last_q == GNT_LSU);
    lsu_gnt  = bus.lsu_valid && !alu_gnt;
    last_d   = last_q;
    if (alu_gnt)      last_d = GNT_ALU;
    else if (lsu_gnt) last_d = GNT_LSU;
    win_rd   = alu_gnt ? bus.alu_rd   : bus.lsu_rd;
    win_data = alu_gnt ? bus.alu_data : bus.lsu_data;
    // x0 writes are accepted but never reach the RegFile
    we_d     = (alu_gnt || lsu_gnt) && (win_rd != ADRESS_WIDTH'(REG_X0));
    waddr_d  = we_d ? win_rd   : waddr_q;
    wdata_d  = we_d ? win_data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= GNT_LSU;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.lsu_ready = lsu_gnt;
  assign bus.rf_we     = we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;
  assign bus.chk_busy0 = busy[0];
  assign bus.chk_busy1 = busy[1];

`ifdef WB_BYPASS_EN
  logic [1:0] hit;
  assign bus.byp_hit0  = hit[0];
  assign bus.byp_hit1  = hit[1];
  assign bus.byp_data0 = wdata_q;
  assign bus.byp_data1 = wdata_q;
`endif

  rf_scoreboard #(.ADRESS_WIDTH(ADRESS_WIDTH), .DEPTH(DEPTH)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .mark_valid_i (bus.mark_valid),
    .mark_rd_i    (bus.mark_rd),
    .clr_valid_i  (lsu_gnt),
    .clr_rd_i     (bus.lsu_rd),
    .rf_we_i      (we_q),
    .rf_waddr_i   (waddr_q),
    .chk_addr_i   ({bus.chk_addr1, bus.chk_addr0}),
    .busy_o       (busy),
`ifdef WB_BYPASS_EN
    .hit_o        (hit),
`endif
    .sb_err_o     (bus.sb_err)
  );
endmodule
